// File: rtl/priority_encoder_rr_pkg.sv
// Shared mode encodings and index-width helper for the priority encoder slice.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Smallest w with 2**w >= n, never below 1; covers n = 2..64.
  function automatic int idx_w(input int n);
    idx_w = 1;
    for (int i = 6; i >= 1; i--) if ((1 << i) >= n) idx_w = i;
  endfunction

endpackage

// File: rtl/priority_encoder_rr_if.sv
// Request/selection bundle between request sources, the encoder and its consumer.
interface priority_encoder_rr_if import prio_enc_pkg::*; #(parameter int N = 8);
  localparam int W = idx_w(N);

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [W-1:0] rr_ptr;

  modport master (output req, mode, out_ready,
                  input  out_valid, out_idx, out_onehot, rr_ptr);
  modport slave  (input  req, mode, out_ready,
                  output out_valid, out_idx, out_onehot, rr_ptr);
endinterface

// File: rtl/priority_encoder_rr_lsb_find.sv
// Combinational lowest-set-bit finder: index and one-hot of the lowest asserted bit.
module lsb_find import prio_enc_pkg::*; #(
  parameter int N = 8,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found  = 1'b1;
        idx    = W'(i);
        onehot = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// N-input fixed/round-robin priority encoder with a registered valid/ready output stage.
module priority_encoder_rr import prio_enc_pkg::*; #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  priority_encoder_rr_if.slave    bus
);
  localparam int W = idx_w(N);

  logic [N-1:0] mask, onehot_m, onehot_u, onehot_sel;
  logic         found_m, found_u;
  logic [W-1:0] idx_m, idx_u, idx_sel;

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         rrg_q, rrg_d;   // held grant was made in round-robin mode
  logic         load, xfer;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (W'(i) >= ptr_q);
  end

  lsb_find #(.N(N)) u_find_m (.vec(bus.req & mask), .found(found_m), .idx(idx_m), .onehot(onehot_m));
  lsb_find #(.N(N)) u_find_u (.vec(bus.req),        .found(found_u), .idx(idx_u), .onehot(onehot_u));

  assign idx_sel    = (bus.mode == MODE_RR && found_m) ? idx_m    : idx_u;
  assign onehot_sel = (bus.mode == MODE_RR && found_m) ? onehot_m : onehot_u;

  assign load = !valid_q || bus.out_ready;
  assign xfer = valid_q && bus.out_ready;

  // Selection uses the pointer from before the edge, even when a transfer updates it.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    rrg_d    = rrg_q;
    if (xfer && rrg_q) ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    if (load) begin
      valid_d = found_u;
      if (found_u) begin
        idx_d    = idx_sel;
        onehot_d = onehot_sel;
        rrg_d    = (bus.mode == MODE_RR);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
      rrg_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
      rrg_q    <= rrg_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.rr_ptr     = ptr_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Scoreboard bench: N=4 and N=5 encoders, directed vectors plus a random N=5 run.
module tb_priority_encoder_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  priority_encoder_rr_if #(.N(4)) b4();
  priority_encoder_rr_if #(.N(5)) b5();

  priority_encoder_rr #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  priority_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  typedef struct { logic v; int idx; int ptr; logic full; } exp_t;
  exp_t q4[$];
  exp_t q5[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, logic v, logic [63:0] idx, logic [63:0] oh,
                     logic [63:0] ptr);
    chk({tag, " out_valid"}, 64'(v), 64'(e.v));
    if (e.v || e.full) begin
      chk({tag, " out_idx"}, idx, 64'(e.idx));
      chk({tag, " out_onehot"}, oh, e.v ? (64'd1 << e.idx) : 64'd0);
    end
    chk({tag, " rr_ptr"}, ptr, 64'(e.ptr));
  endtask

  exp_t e4, e5;
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      cmp("n4", e4, b4.out_valid, 64'(b4.out_idx), 64'(b4.out_onehot), 64'(b4.rr_ptr));
    end
  end
  always @(negedge clk) begin
    if (q5.size() > 0) begin
      e5 = q5.pop_front();
      cmp("n5", e5, b5.out_valid, 64'(b5.out_idx), 64'(b5.out_onehot), 64'(b5.rr_ptr));
    end
  end

  // Apply inputs, take one edge, then record the hand-computed state after that edge.
  task automatic cyc4(logic [3:0] r, logic md, logic rdy, logic ev, int ei, int ep);
    b4.req = r; b4.mode = md; b4.out_ready = rdy;
    @(posedge clk); #1;
    q4.push_back('{v: ev, idx: ei, ptr: ep, full: 1'b0});
  endtask

  task automatic cyc5(logic [4:0] r, logic md, logic rdy, logic ev, int ei, int ep);
    b5.req = r; b5.mode = md; b5.out_ready = rdy;
    @(posedge clk); #1;
    q5.push_back('{v: ev, idx: ei, ptr: ep, full: 1'b0});
  endtask

  task automatic push_reset();
    q4.push_back('{v: 1'b0, idx: 0, ptr: 0, full: 1'b1});
    q5.push_back('{v: 1'b0, idx: 0, ptr: 0, full: 1'b1});
  endtask

  int         m_v, m_idx, m_ptr, nptr, sel;
  logic       m_rrg, md, rdy;
  logic [4:0] r;

  initial begin
    b4.req = '0; b4.mode = 1'b0; b4.out_ready = 1'b1;
    b5.req = '0; b5.mode = 1'b0; b5.out_ready = 1'b1;
    @(posedge clk); #1;
    push_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed priority
    cyc4(4'b1010, 1'b0, 1'b1, 1'b1, 1, 0);
    cyc4(4'b1000, 1'b0, 1'b1, 1'b1, 3, 0);
    cyc4(4'b0000, 1'b0, 1'b1, 1'b0, 3, 0);
    // Stall: held idx 2 ignores the changed request
    cyc4(4'b0100, 1'b0, 1'b1, 1'b1, 2, 0);
    repeat (3) cyc4(4'b0001, 1'b0, 1'b0, 1'b1, 2, 0);
    cyc4(4'b0001, 1'b0, 1'b1, 1'b1, 0, 0);
    cyc4(4'b0000, 1'b0, 1'b1, 1'b0, 0, 0);
    // Round-robin, all requesting: each grant is computed from the pre-update pointer
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 0, 0);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 0, 1);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 1, 1);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 1, 2);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 2, 2);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 2, 3);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 3, 3);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 3, 0);
    cyc4(4'b1111, 1'b1, 1'b1, 1'b1, 0, 0);
    cyc4(4'b0000, 1'b1, 1'b1, 1'b0, 0, 1);
    // Wrap from pointer 3
    cyc4(4'b0100, 1'b1, 1'b1, 1'b1, 2, 1);
    cyc4(4'b0000, 1'b1, 1'b1, 1'b0, 2, 3);
    cyc4(4'b0101, 1'b1, 1'b1, 1'b1, 0, 3);
    cyc4(4'b0101, 1'b1, 1'b1, 1'b1, 0, 1);
    cyc4(4'b0101, 1'b1, 1'b1, 1'b1, 2, 1);
    cyc4(4'b0000, 1'b1, 1'b1, 1'b0, 2, 3);
    // Fixed grants leave the pointer alone; round-robin resumes from it
    cyc4(4'b0010, 1'b0, 1'b1, 1'b1, 1, 3);
    cyc4(4'b0000, 1'b0, 1'b1, 1'b0, 1, 3);
    cyc4(4'b1001, 1'b1, 1'b1, 1'b1, 3, 3);
    cyc4(4'b0000, 1'b1, 1'b1, 1'b0, 3, 0);
    // Async reset while holding a valid selection with a non-zero pointer
    cyc4(4'b0110, 1'b1, 1'b1, 1'b1, 1, 0);
    cyc4(4'b0110, 1'b1, 1'b1, 1'b1, 1, 2);
    b4.out_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    push_reset();
    #1;
    chk("async_rst out_valid", 64'(b4.out_valid), 64'd0);
    chk("async_rst rr_ptr", 64'(b4.rr_ptr), 64'd0);
    b4.req = '0; b4.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // N=5 round-robin on inputs 0 and 4
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 0, 0);
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 0, 1);
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 4, 1);
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 4, 0);
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 0, 0);
    cyc5(5'b10001, 1'b1, 1'b1, 1'b1, 0, 1);
    cyc5(5'b00000, 1'b1, 1'b1, 1'b0, 0, 1);

    // Random run against a behavioural reference model
    m_v = 0; m_idx = 0; m_ptr = 1; m_rrg = 1'b1;
    repeat (10000) begin
      r   = 5'($urandom);
      md  = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      nptr = m_ptr;
      if (m_v != 0 && rdy && m_rrg) nptr = (m_idx == 4) ? 0 : m_idx + 1;
      if (m_v == 0 || rdy) begin
        if (r != 5'd0) begin
          sel = -1;
          if (md) for (int i = m_ptr; i < 5; i++) if (r[i] && sel < 0) sel = i;
          if (sel < 0) for (int i = 0; i < 5; i++) if (r[i] && sel < 0) sel = i;
          m_idx = sel; m_v = 1; m_rrg = md;
        end else begin
          m_v = 0;
        end
      end
      m_ptr = nptr;
      cyc5(r, md, rdy, (m_v != 0), m_idx, m_ptr);
    end

    @(negedge clk); #1;
    chk("scoreboard n4 drained", 64'(q4.size()), 64'd0);
    chk("scoreboard n5 drained", 64'(q5.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
